// File: rtl/rob_ctrl_if.sv
// Dispatch / data-store handshake bundle for rob_ctrl.
// master = dispatch and data-store side, slave = rob_ctrl.
interface rob_ctrl_if #(
  parameter int unsigned PTR_W = 6
);
  logic             alloc_req;
  logic             alloc_gnt;
  logic [PTR_W-1:0] alloc_tag;
  logic             retire_valid;
  logic             retire_ack;
  logic [PTR_W-1:0] rob_fifo_head;
  logic             flush_req;
  logic             flush;
  logic             rob_full;
  logic             rob_empty;
  logic [PTR_W:0]   rob_count;
  logic             busy;
  logic [31:0]      full_stall_cnt;
  logic [31:0]      retire_cnt;

  modport master (
    output alloc_req, retire_valid, flush_req,
    input  alloc_gnt, alloc_tag, retire_ack, rob_fifo_head, flush,
           rob_full, rob_empty, rob_count, busy, full_stall_cnt, retire_cnt
  );

  modport slave (
    input  alloc_req, retire_valid, flush_req,
    output alloc_gnt, alloc_tag, retire_ack, rob_fifo_head, flush,
           rob_full, rob_empty, rob_count, busy, full_stall_cnt, retire_cnt
  );
endinterface

// File: rtl/rob_ctrl.sv
// Reorder-buffer pointer/occupancy controller with flush/recover sequencing.
// Optional performance counters are enabled by defining ROB_PERF_CNT_EN.
module rob_ctrl #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned PTR_W = 6
) (
  input  logic         clk,
  input  logic         i_rst_n,
  rob_ctrl_if.slave    rob
);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  state_e           state;
  state_e           state_nx;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             flush_q;

  logic run_c;
  logic busy_c;
  logic full_c;
  logic empty_c;
  logic gnt_c;
  logic ack_c;
  logic enter_flush_c;

  // State register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_RUN;
    else          state <= state_nx;
  end

  // Next-state logic; flush_req only matters in RUN
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RUN:     if (rob.flush_req) state_nx = ST_FLUSH;
      ST_FLUSH:   state_nx = ST_RECOVER;
      ST_RECOVER: state_nx = ST_RUN;
      default:    state_nx = ST_RUN;
    endcase
  end

  // Output / handshake decode
  always_comb begin
    run_c         = (state == ST_RUN);
    busy_c        = ~run_c;
    full_c        = (count == CNT_W'(DEPTH));
    empty_c       = (count == '0);
    gnt_c         = rob.alloc_req & ~full_c & run_c & ~rob.flush_req;
    ack_c         = rob.retire_valid & ~empty_c & run_c;
    enter_flush_c = run_c & rob.flush_req;
  end

  // Flush pulse flop tracks the FLUSH state so the data store sees a clean edge
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) flush_q <= 1'b0;
    else          flush_q <= (state_nx == ST_FLUSH);
  end

  // Head/tail/occupancy; entering FLUSH overrides any same-cycle grant or retire
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (enter_flush_c) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (gnt_c) tail <= tail + PTR_W'(1);
      if (ack_c) head <= head + PTR_W'(1);
      unique case ({gnt_c, ack_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] retire_cnt_q;

  // Saturating counters, deliberately untouched by flush
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (rob.alloc_req && full_c && run_c && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ack_c && (retire_cnt_q != 32'hFFFF_FFFF))
        retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign rob.full_stall_cnt = stall_cnt_q;
  assign rob.retire_cnt     = retire_cnt_q;
`else
  assign rob.full_stall_cnt = 32'd0;
  assign rob.retire_cnt     = 32'd0;
`endif

  assign rob.alloc_gnt     = gnt_c;
  assign rob.alloc_tag     = tail;
  assign rob.retire_ack    = ack_c;
  assign rob.rob_fifo_head = head;
  assign rob.flush         = flush_q;
  assign rob.rob_full      = full_c;
  assign rob.rob_empty     = empty_c;
  assign rob.rob_count     = count;
  assign rob.busy          = busy_c;

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: vector table plus hand-written wrap/flush/reset sequences.
module tb_rob_ctrl;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned PTR_W = 6;

  logic clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rob_ctrl_if #(.PTR_W(PTR_W)) bus ();

  rob_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .rob     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       r;
    logic       f;
    logic       gnt;
    logic       ack;
    logic [5:0] tag;
    logic [5:0] head;
    logic [6:0] cnt;
    logic       full;
    logic       empty;
    logic       busy;
    logic       fl;
  } vec_t;

  vec_t vecs[14];

`ifdef ROB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic r, input logic f);
    bus.alloc_req    = a;
    bus.retire_valid = r;
    bus.flush_req    = f;
  endtask

  // Reset and leave the bench aligned on a falling edge
  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0);
    i_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int seen;
    //            a  r  f  gnt ack tag head cnt full empty busy fl
    vecs[0]  = '{0, 0, 0, 0,  0,  0,  0,   0,  0,   1,    0,   0};
    vecs[1]  = '{1, 0, 0, 1,  0,  0,  0,   0,  0,   1,    0,   0};
    vecs[2]  = '{1, 1, 0, 1,  1,  1,  0,   1,  0,   0,    0,   0};
    vecs[3]  = '{0, 1, 0, 0,  1,  2,  1,   1,  0,   0,    0,   0};
    vecs[4]  = '{0, 1, 0, 0,  0,  2,  2,   0,  0,   1,    0,   0};
    vecs[5]  = '{1, 0, 0, 1,  0,  2,  2,   0,  0,   1,    0,   0};
    vecs[6]  = '{1, 0, 0, 1,  0,  3,  2,   1,  0,   0,    0,   0};
    vecs[7]  = '{1, 0, 0, 1,  0,  4,  2,   2,  0,   0,    0,   0};
    vecs[8]  = '{1, 1, 1, 0,  1,  5,  2,   3,  0,   0,    0,   0};
    vecs[9]  = '{1, 1, 0, 0,  0,  0,  0,   0,  0,   1,    1,   1};
    vecs[10] = '{1, 0, 1, 0,  0,  0,  0,   0,  0,   1,    1,   0};
    vecs[11] = '{1, 0, 0, 1,  0,  0,  0,   0,  0,   1,    0,   0};
    vecs[12] = '{0, 1, 0, 0,  1,  1,  0,   1,  0,   0,    0,   0};
    vecs[13] = '{0, 0, 0, 0,  0,  1,  1,   0,  0,   1,    0,   0};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].a, vecs[i].r, vecs[i].f);
      #1;
      chk($sformatf("v%0d gnt", i),   32'(bus.alloc_gnt),     32'(vecs[i].gnt));
      chk($sformatf("v%0d ack", i),   32'(bus.retire_ack),    32'(vecs[i].ack));
      chk($sformatf("v%0d tag", i),   32'(bus.alloc_tag),     32'(vecs[i].tag));
      chk($sformatf("v%0d head", i),  32'(bus.rob_fifo_head), 32'(vecs[i].head));
      chk($sformatf("v%0d cnt", i),   32'(bus.rob_count),     32'(vecs[i].cnt));
      chk($sformatf("v%0d full", i),  32'(bus.rob_full),      32'(vecs[i].full));
      chk($sformatf("v%0d empty", i), 32'(bus.rob_empty),     32'(vecs[i].empty));
      chk($sformatf("v%0d busy", i),  32'(bus.busy),          32'(vecs[i].busy));
      chk($sformatf("v%0d flush", i), 32'(bus.flush),         32'(vecs[i].fl));
      @(negedge clk);
    end

    // Fill to DEPTH, stall, then retire+request on a full ROB and wrap the tail
    do_reset();
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      #1;
      chk($sformatf("fill gnt %0d", i), 32'(bus.alloc_gnt), 32'd1);
      chk($sformatf("fill tag %0d", i), 32'(bus.alloc_tag), 32'(i));
      @(negedge clk);
    end
    #1;
    chk("full flag", 32'(bus.rob_full), 32'd1);
    chk("full count", 32'(bus.rob_count), 32'd64);
    chk("65th gnt", 32'(bus.alloc_gnt), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("stall cnt", bus.full_stall_cnt, PERF ? 32'd3 : 32'd0);
    drive(1'b1, 1'b1, 1'b0);
    #1;
    chk("full gnt", 32'(bus.alloc_gnt), 32'd0);
    chk("full ack", 32'(bus.retire_ack), 32'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0);
    #1;
    chk("post-retire count", 32'(bus.rob_count), 32'd63);
    chk("wrap gnt", 32'(bus.alloc_gnt), 32'd1);
    chk("wrap tag", 32'(bus.alloc_tag), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("refill count", 32'(bus.rob_count), 32'd64);
    chk("retire cnt", bus.retire_cnt, PERF ? 32'd1 : 32'd0);

    // Count 10 at head 60, then 8 cycles of simultaneous grant and retire
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    repeat (60) @(negedge clk);
    drive(1'b0, 1'b1, 1'b0);
    repeat (60) @(negedge clk);
    drive(1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    drive(1'b1, 1'b1, 1'b0);
    #1;
    chk("steady head start", 32'(bus.rob_fifo_head), 32'd60);
    chk("steady count start", 32'(bus.rob_count), 32'd10);
    chk("steady both", 32'({bus.alloc_gnt, bus.retire_ack}), 32'd3);
    repeat (8) @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("steady count", 32'(bus.rob_count), 32'd10);
    chk("steady head wrap", 32'(bus.rob_fifo_head), 32'd4);
    chk("steady tag", 32'(bus.alloc_tag), 32'd14);

    // Reset asserted in FLUSH kills the pulse and no further pulse follows
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    drive(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("in flush", 32'(bus.flush), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("rst flush", 32'(bus.flush), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst empty", 32'(bus.rob_empty), 32'd1);
    @(negedge clk);
    i_rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.flush !== 1'b0 || bus.busy !== 1'b0) seen++;
      @(negedge clk);
    end
    chk("no pulse after rst", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
